// File: rtl/pool2_pkg.sv
// Shared constants and FSM encoding for the layer-2 pool sequencer.
// Map/pass/word geometry and the result-store address width.
package pool2_pkg;

  localparam int NUM_FM    = 12;
  localparam int NUM_PASS  = 3;
  localparam int MAP_WORDS = 60;
  localparam int POOL_OUTS = 9;
  localparam int DRAIN_MAX = 32;

  localparam int FM_W   = 4;
  localparam int BEAT_W = 6;
  localparam int PASS_W = 2;
  localparam int IDX_W  = 4;
  localparam int DCNT_W = 5;
  localparam int ADDR_W = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/pool2_seq_ctrl.sv
// Sequencer for the layer-2 accumulate/ReLU/max-pool datapath.
// Ports: cnn_clk, rst_n, start, in_valid/in_ready/wr_en (conv2 beats),
// conv1_done, feature_map_counter, buffer_en/out_we/out_addr (results),
// busy, done, err_timeout. POOL2_PERF_CNT_EN adds stall_cycles and
// frame_cycles.
module pool2_seq_ctrl
  import pool2_pkg::*;
(
  input  logic              cnn_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic              conv1_done,
  output logic [FM_W-1:0]   feature_map_counter,
  input  logic              buffer_en,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
`ifdef POOL2_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       frame_cycles
`endif
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAP_WORDS - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASS - 1);
  localparam logic [FM_W-1:0]   LAST_FM   = FM_W'(NUM_FM - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(POOL_OUTS - 1);
  localparam logic [DCNT_W-1:0] LAST_DCNT = DCNT_W'(DRAIN_MAX - 1);

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [PASS_W-1:0]  pass_q, pass_d;
  logic [FM_W-1:0]    fm_q, fm_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic               err_q, err_d;
  logic               rdy_q, c1d_q, done_q;

  assign in_ready            = rdy_q;
  assign wr_en               = in_valid & rdy_q;
  assign out_we              = buffer_en & (state_q == S_DRAIN);
  assign busy                = (state_q != S_IDLE);
  assign done                = done_q;
  assign conv1_done          = c1d_q;
  assign err_timeout         = err_q;
  assign feature_map_counter = fm_q;
  assign out_addr            = ADDR_W'(fm_q) * ADDR_W'(POOL_OUTS)
                             + ADDR_W'(idx_q);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pass_d  = pass_q;
    fm_d    = fm_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          beat_d  = '0;
          pass_d  = '0;
          fm_d    = '0;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_ACCUM: begin
        if (wr_en) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (pass_q == LAST_PASS) begin
              pass_d  = '0;
              idx_d   = '0;
              dcnt_d  = '0;
              state_d = S_DRAIN;
            end else begin
              pass_d = pass_q + 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        // a completing strobe wins over a same-cycle timeout
        if (out_we && idx_q == LAST_IDX) begin
          idx_d = '0;
          if (fm_q == LAST_FM) begin
            state_d = S_DONE;
          end else begin
            fm_d    = fm_q + 1'b1;
            state_d = S_ACCUM;
          end
        end else begin
          if (out_we) idx_d = idx_q + 1'b1;
          if (dcnt_q == LAST_DCNT) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge cnn_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      pass_q  <= '0;
      fm_q    <= '0;
      idx_q   <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      c1d_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      pass_q  <= pass_d;
      fm_q    <= fm_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
      rdy_q   <= (state_d == S_ACCUM);
      c1d_q   <= (state_d == S_ACCUM) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
    end
  end

`ifdef POOL2_PERF_CNT_EN
  logic [15:0] stall_q, frame_q;

  always_ff @(posedge cnn_clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      frame_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_q <= '0;
      frame_q <= '0;
    end else begin
      if (state_q == S_ACCUM && !in_valid && stall_q != 16'hFFFF)
        stall_q <= stall_q + 1'b1;
      if (busy && frame_q != 16'hFFFF)
        frame_q <= frame_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign frame_cycles = frame_q;
`endif

endmodule

// File: tb/tb_pool2_seq_ctrl.sv
// Self-checking bench for pool2_seq_ctrl: scenario table plus a
// map/word/strobe-level reference model driving a datapath stub.
module tb_pool2_seq_ctrl;

  localparam int FMS = 12;
  localparam int WORDS_PER_MAP = 180;
  localparam int OUTS = 9;
  localparam int DMAX = 32;
  localparam int LAT = 4;

  localparam int P_IDLE = 0;
  localparam int P_ACC  = 1;
  localparam int P_DRN  = 2;
  localparam int P_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       buffer_en = 1'b0;
  logic       in_ready, wr_en, conv1_done;
  logic [3:0] feature_map_counter;
  logic       out_we;
  logic [6:0] out_addr;
  logic       busy, done, err_timeout;
`ifdef POOL2_PERF_CNT_EN
  logic [15:0] stall_cycles, frame_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pool2_seq_ctrl dut (
    .cnn_clk             (clk),
    .rst_n               (rst_n),
    .start               (start),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .wr_en               (wr_en),
    .conv1_done          (conv1_done),
    .feature_map_counter (feature_map_counter),
    .buffer_en           (buffer_en),
    .out_we              (out_we),
    .out_addr            (out_addr),
    .busy                (busy),
    .done                (done),
    .err_timeout         (err_timeout)
`ifdef POOL2_PERF_CNT_EN
    ,
    .stall_cycles        (stall_cycles),
    .frame_cycles        (frame_cycles)
`endif
  );

  typedef struct {
    int mode;
    int nstb;
    int stop;
    int exp_wr;
    int exp_we;
    int exp_last;
    int exp_done;
    int exp_err;
  } tv_t;

  tv_t tv [7];

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic run_frame(input tv_t t, output int wr, output int we,
                           output int last, output int gdone);
    int n = 0, k = 0, m = 0, dc = 0;
    int wait_c = 0, left = 0, cyc = 0;
    int ph;
    bit v, b, ew, abort;
`ifdef POOL2_PERF_CNT_EN
    int stall = 0, frm = 0;
`endif
    wr = 0; we = 0; last = -1; gdone = 0; abort = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ph = P_ACC;
    chk("err_clr_on_start", int'(err_timeout), 0);
    while (cyc < 20000) begin
      cyc++;
      chk("in_ready", int'(in_ready), int'(ph == P_ACC));
      chk("conv1_done", int'(conv1_done), int'(ph == P_ACC || ph == P_DRN));
      chk("done", int'(done), int'(ph == P_DONE));
      chk("busy", int'(busy), int'(ph != P_IDLE));
      if (done) gdone = 1;
      if (ph == P_IDLE) break;
      chk("fm", int'(feature_map_counter), m);
      unique case (t.mode)
        0: v = 1'b1;
        1: v = (cyc % 2) == 1;
        2: v = 1'($urandom_range(0, 1));
        default: v = $urandom_range(0, 3) != 0;
      endcase
      b = 1'b0;
      if (wait_c > 0) wait_c--;
      if (wait_c == 0 && left > 0) begin
        b = 1'b1;
        left--;
      end
      if (t.mode == 3 && ph == P_ACC) b = 1'($urandom_range(0, 1));
      start = (t.mode == 1 && cyc == 50);
      in_valid = v;
      buffer_en = b;
      #1;
      ew = b && ph == P_DRN;
      chk("wr_en", int'(wr_en), int'(v && ph == P_ACC));
      chk("out_we", int'(out_we), int'(ew));
      if (ew) chk("out_addr", int'(out_addr), m * OUTS + k);
      if (wr_en) wr++;
      if (out_we) begin
        we++;
        last = int'(out_addr);
      end
`ifdef POOL2_PERF_CNT_EN
      if (ph == P_ACC && !v) stall++;
      frm++;
`endif
      if (ph == P_ACC) begin
        if (v) begin
          n++;
          if (t.stop > 0 && m * WORDS_PER_MAP + n == t.stop) abort = 1;
          if (n == WORDS_PER_MAP) begin
            ph = P_DRN;
            dc = 0;
            k = 0;
            wait_c = LAT;
            left = t.nstb;
          end
        end
      end else if (ph == P_DRN) begin
        dc++;
        if (ew) k++;
        if (k == OUTS) begin
          if (m == FMS - 1) begin
            ph = P_DONE;
          end else begin
            m++;
            n = 0;
            ph = P_ACC;
          end
        end else if (dc == DMAX) begin
          ph = P_IDLE;
        end
      end else if (ph == P_DONE) begin
        ph = P_IDLE;
      end
      if (abort) break;
      @(negedge clk);
    end
    if (cyc >= 20000) chk("frame_cycle_bound", 0, 1);
    start = 1'b0;
    in_valid = 1'b0;
    buffer_en = 1'b0;
`ifdef POOL2_PERF_CNT_EN
    if (gdone != 0) begin
      chk("stall_cycles", int'(stall_cycles), stall);
      chk("frame_cycles", int'(frame_cycles), frm);
    end
`endif
  endtask

  initial begin
    int wr, we, last, gdone;
    tv[0] = '{0, 9, 0, 2160, 108, 107, 1, 0};
    tv[1] = '{1, 9, 0, 2160, 108, 107, 1, 0};
    tv[2] = '{2, 9, 0, 2160, 108, 107, 1, 0};
    tv[3] = '{3, 9, 0, 2160, 108, 107, 1, 0};
    tv[4] = '{0, 5, 0, 180, 5, 4, 0, 1};
    tv[5] = '{0, 9, 3 * 180 + 90, 630, 27, 26, 0, 0};
    tv[6] = '{0, 9, 0, 2160, 108, 107, 1, 0};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_conv1_done", int'(conv1_done), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err_timeout), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fm", int'(feature_map_counter), 0);
    chk("rst_addr", int'(out_addr), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_frame(tv[i], wr, we, last, gdone);
      chk($sformatf("v%0d_wr_total", i), wr, tv[i].exp_wr);
      chk($sformatf("v%0d_we_total", i), we, tv[i].exp_we);
      chk($sformatf("v%0d_last_addr", i), last, tv[i].exp_last);
      chk($sformatf("v%0d_done_seen", i), gdone, tv[i].exp_done);
      chk($sformatf("v%0d_err", i), int'(err_timeout), tv[i].exp_err);
      if (tv[i].stop > 0) begin
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", int'(in_ready), 0);
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_conv1_done", int'(conv1_done), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(err_timeout), 0);
        chk("abort_fm", int'(feature_map_counter), 0);
        chk("abort_addr", int'(out_addr), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DMAX + 8) @(negedge clk);
      end else begin
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
